alu_seq_display: RTL and testbench
==================================

ALU_SEQ_DISPLAY -- requirements
Module: alu_seq_display

Interface
REQ-001 Parameter WIDTH, default 8, operand/result width in bits (range 4..16).
REQ-002 Parameter DIGITS, default 4, number of seven-segment digits driven.
REQ-003 Parameter DIVIDER, default 100000, clk cycles per digit scan slot.
REQ-004 clk  input  1  single system clock; all state updates on rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 din  input  WIDTH  operand data.
REQ-007 load_a  input  1  capture din into operand A.
REQ-008 load_b  input  1  capture din into operand B.
REQ-009 op  input  3  operation select.
REQ-010 signed_mode  input  1  1 = result displayed as two's-complement with sign.
REQ-011 flags  output  4  {N,Z,C,V}, registered.
REQ-012 busy  output  1  high while BCD conversion in progress.
REQ-013 seg  output  8  active-low segments {dp,g..a}; dp always 1 (off).
REQ-014 an  output  DIGITS  active-low digit enables, one-hot-low.

Function
REQ-015 A/B load on the clock edge where load_a/load_b is high; both high loads both with din.
REQ-016 op encoding: 000 ADD A+B, 001 INC A+1, 010 SUB A-B, 011 XOR, 100 OR, 101 AND, 110 SHL A<<1, 111 SHR A>>1 (logical).
REQ-017 result register and flags update every cycle from current A, B, op; latency one cycle after operand/op change; result truncated to WIDTH bits.
REQ-018 Z = (result==0); N = result[WIDTH-1]; C = carry-out for ADD/INC, borrow (A<B unsigned) for SUB, shifted-out bit for SHL/SHR, 0 for logic ops.
REQ-019 V = signed overflow for ADD/INC/SUB, 0 otherwise.
REQ-020 Converter source: result if signed_mode=0 or N=0, else two's-complement magnitude; sign flag captured with source.
REQ-021 Converter FSM states IDLE, SHIFT, DONE; IDLE -> SHIFT when source or sign differs from held snapshot, snapshot loaded on that edge.
REQ-022 SHIFT performs one shift-add-3 iteration per cycle, exactly WIDTH cycles, then DONE.
REQ-023 DONE (one cycle) copies BCD and sign into display register, returns to IDLE.
REQ-024 In SHIFT, if source/sign changes from snapshot, abort to IDLE next cycle without updating display register; restart follows.
REQ-025 busy = 1 in SHIFT and DONE only.
REQ-026 Scan counter counts 0..DIVIDER-1 and wraps; on wrap digit index increments 0..DIGITS-1 and wraps to 0.
REQ-027 Digit 0 = units; an[i] low only when digit index == i; seg and an registered.
REQ-028 Leading-zero digits blanked (seg all 1); units digit always shown, so value 0 shows "0".
REQ-029 Negative sign shown as segment g only (seg=8'b1011_1111) on digit DIGITS-1; that digit is never used for magnitude.
REQ-030 Elaboration check: ceil(WIDTH*log10(2)) <= DIGITS-1, otherwise error.

Reset
REQ-031 On rst: A, B, result, flags, snapshot, display register = 0; FSM = IDLE; busy = 0; scan counter and digit index = 0.
REQ-032 During rst and the following cycle, an = all 1 and seg = all 1; next scan displays "0".
REQ-033 rst mid-conversion discards the conversion; no display update.

Structure
REQ-034 Shared package alu_seq_pkg holds op encodings, FSM state type, seven-segment digit and minus patterns.
REQ-035 Sub-module bin2bcd_seq holds the iterative converter FSM (start, source, busy, done, bcd out).

Verification
REQ-036 WIDTH=8: A=200, B=100, op=ADD -> result 44, flags C=1 Z=0 V=0, display "44", digits 2-3 blank.
REQ-037 A=5, B=10, op=SUB, signed_mode=1 -> result 251, N=1 C=1, display "-  5"; signed_mode=0 -> "251".
REQ-038 A=127, op=INC -> result 128, V=1 N=1; busy high exactly 9 cycles (8 SHIFT + DONE).
REQ-039 Change B 3 cycles into SHIFT -> abort, restart, display shows only final value, never the intermediate.
REQ-040 DIVIDER=4: an sequence 1110,1101,1011,0111, each held 4 cycles, then repeats; rst mid-conversion -> all-off then "0".

Source files
------------

// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: shared op codes, converter states and seven-segment patterns
package alu_seq_pkg;
  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_INC = 3'b001,
    OP_SUB = 3'b010,
    OP_XOR = 3'b011,
    OP_OR  = 3'b100,
    OP_AND = 3'b101,
    OP_SHL = 3'b110,
    OP_SHR = 3'b111
  } op_e;
  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} bcd_state_e;
  localparam logic [7:0] SEG_BLANK = 8'hFF;
  localparam logic [7:0] SEG_MINUS = 8'hBF;
  function automatic logic [7:0] seg7(input logic [3:0] d);
    case (d)
      4'd0: return 8'hC0;
      4'd1: return 8'hF9;
      4'd2: return 8'hA4;
      4'd3: return 8'hB0;
      4'd4: return 8'h99;
      4'd5: return 8'h92;
      4'd6: return 8'h82;
      4'd7: return 8'hF8;
      4'd8: return 8'h80;
      4'd9: return 8'h90;
      default: return SEG_BLANK;
    endcase
  endfunction
  function automatic int dec_digits(input int w);
    longint v;
    int n;
    v = (longint'(1) << w) - 1;
    n = 0;
    for (int i = 0; i < 8; i++)
      if (v > 0) begin
        v = v / 10;
        n++;
      end
    return n;
  endfunction
endpackage

// File: rtl/alu_seq_display_if.sv
// alu_seq_display_if: operand/op inputs and flag/display outputs of the ALU display block
interface alu_seq_display_if #(parameter int WIDTH = 8, parameter int DIGITS = 4);
  logic [WIDTH-1:0] din;
  logic load_a;
  logic load_b;
  logic [2:0] op;
  logic signed_mode;
  logic [3:0] flags;
  logic busy;
  logic [7:0] seg;
  logic [DIGITS-1:0] an;
  modport master (output din, load_a, load_b, op, signed_mode, input flags, busy, seg, an);
  modport slave (input din, load_a, load_b, op, signed_mode, output flags, busy, seg, an);
endinterface

// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: iterative shift-add-3 converter restarting whenever its source changes
module bin2bcd_seq
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int BCD_DIGITS = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic [WIDTH-1:0] src,
  input  logic sign_in,
  output logic busy,
  output logic done,
  output logic [4*BCD_DIGITS-1:0] bcd,
  output logic sign_out
);
  localparam int BW = 4 * BCD_DIGITS;
  localparam int CW = $clog2(WIDTH);
  bcd_state_e state, state_n;
  logic [WIDTH-1:0] snap_src, bin;
  logic snap_sign, start;
  logic [BW-1:0] bcd_r, adj;
  logic [BW+WIDTH-1:0] sh;
  logic [CW-1:0] cnt;
  assign start = {src, sign_in} != {snap_src, snap_sign};
  // state register
  always_ff @(posedge clk)
    state <= rst ? S_IDLE : state_n;
  // next state: a source change in SHIFT aborts, the following IDLE cycle restarts
  always_comb
    state_n = state == S_IDLE ? (start ? S_SHIFT : S_IDLE) :
              state == S_SHIFT ? (start ? S_IDLE : cnt == CW'(WIDTH - 1) ? S_DONE : S_SHIFT) :
              S_IDLE;
  // outputs decoded from state
  always_comb begin
    busy = state != S_IDLE;
    done = state == S_DONE;
  end
  // one shift-add-3 step on the BCD digits and remaining binary bits
  always_comb begin
    adj = bcd_r;
    for (int i = 0; i < BCD_DIGITS; i++)
      adj[4*i+:4] = adj[4*i+:4] >= 4'd5 ? adj[4*i+:4] + 4'd3 : adj[4*i+:4];
    sh = {adj, bin} << 1;
  end
  // snapshot capture on start, iteration in SHIFT
  always_ff @(posedge clk)
    if (rst) begin
      snap_src <= '0;
      snap_sign <= 1'b0;
      bin <= '0;
      bcd_r <= '0;
      cnt <= '0;
    end else if (state == S_IDLE && start) begin
      snap_src <= src;
      snap_sign <= sign_in;
      bin <= src;
      bcd_r <= '0;
      cnt <= '0;
    end else if (state == S_SHIFT) begin
      {bcd_r, bin} <= sh;
      cnt <= cnt + 1'b1;
    end
  assign bcd = bcd_r;
  assign sign_out = snap_sign;
endmodule

// File: rtl/alu_seq_display.sv
// alu_seq_display: registered ALU with flags, decimal conversion and multiplexed seven-segment scan
module alu_seq_display
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIGITS = 4,
  parameter int DIVIDER = 100000
) (
  input logic clk,
  input logic rst,
  alu_seq_display_if.slave bus
);
  localparam int MD = DIGITS - 1;
  localparam int BW = 4 * MD;
  localparam int CW = DIVIDER > 1 ? $clog2(DIVIDER) : 1;
  localparam int IW = DIGITS > 1 ? $clog2(DIGITS) : 1;
  if (dec_digits(WIDTH) > MD) begin : g_digits_check
    $error("alu_seq_display: DIGITS too small for WIDTH");
  end
  op_e op;
  logic [WIDTH-1:0] a, b, res, res_n, rhs, src;
  logic [WIDTH:0] add, sub;
  logic c_n, v_n, neg, busy, done, sign_out, disp_sign, warm;
  logic [3:0] flags_r;
  logic [BW-1:0] bcd, disp_bcd;
  logic [4*DIGITS-1:0] pad;
  logic [CW-1:0] cnt;
  logic [IW-1:0] idx;
  logic [3:0] nib;
  logic [7:0] seg_n, seg_r;
  logic [DIGITS-1:0] an_n, an_r;
  assign op = op_e'(bus.op);
  // ALU result, carry/borrow and signed overflow for the selected op
  always_comb begin
    rhs = op == OP_INC ? WIDTH'(1) : b;
    add = {1'b0, a} + {1'b0, rhs};
    sub = {1'b0, a} - {1'b0, b};
    res_n = '0;
    c_n = 1'b0;
    v_n = 1'b0;
    case (op)
      OP_ADD, OP_INC: begin
        res_n = add[WIDTH-1:0];
        c_n = add[WIDTH];
        v_n = a[WIDTH-1] == rhs[WIDTH-1] && res_n[WIDTH-1] != a[WIDTH-1];
      end
      OP_SUB: begin
        res_n = sub[WIDTH-1:0];
        c_n = sub[WIDTH];
        v_n = a[WIDTH-1] != b[WIDTH-1] && res_n[WIDTH-1] != a[WIDTH-1];
      end
      OP_XOR: res_n = a ^ b;
      OP_OR:  res_n = a | b;
      OP_AND: res_n = a & b;
      OP_SHL: begin
        res_n = {a[WIDTH-2:0], 1'b0};
        c_n = a[WIDTH-1];
      end
      OP_SHR: begin
        res_n = {1'b0, a[WIDTH-1:1]};
        c_n = a[0];
      end
    endcase
  end
  // operand loads and per-cycle result/flag registers
  always_ff @(posedge clk)
    if (rst) begin
      a <= '0;
      b <= '0;
      res <= '0;
      flags_r <= '0;
    end else begin
      if (bus.load_a) a <= bus.din;
      if (bus.load_b) b <= bus.din;
      res <= res_n;
      flags_r <= {res_n[WIDTH-1], res_n == '0, c_n, v_n};
    end
  assign neg = bus.signed_mode && res[WIDTH-1];
  assign src = neg ? ~res + WIDTH'(1) : res;
  bin2bcd_seq #(.WIDTH(WIDTH), .BCD_DIGITS(MD)) u_conv (
    .clk(clk),
    .rst(rst),
    .src(src),
    .sign_in(neg),
    .busy(busy),
    .done(done),
    .bcd(bcd),
    .sign_out(sign_out)
  );
  // display register takes only completed conversions
  always_ff @(posedge clk)
    if (rst) begin
      disp_bcd <= '0;
      disp_sign <= 1'b0;
    end else if (done) begin
      disp_bcd <= bcd;
      disp_sign <= sign_out;
    end
  // scan timing; held for the blank cycle after reset so every slot lasts DIVIDER cycles
  always_ff @(posedge clk)
    if (rst) begin
      warm <= 1'b0;
      cnt <= '0;
      idx <= '0;
    end else begin
      warm <= 1'b1;
      if (warm) begin
        cnt <= cnt == CW'(DIVIDER - 1) ? '0 : cnt + 1'b1;
        if (cnt == CW'(DIVIDER - 1)) idx <= idx == IW'(DIGITS - 1) ? '0 : idx + 1'b1;
      end
    end
  // segment pattern for the scanned digit: sign slot, leading-zero blanking, units always lit
  always_comb begin
    pad = {4'h0, disp_bcd};
    nib = pad[4*idx+:4];
    seg_n = idx == IW'(DIGITS - 1) ? (disp_sign ? SEG_MINUS : SEG_BLANK) :
            idx != '0 && (pad >> (4 * idx)) == '0 ? SEG_BLANK : seg7(nib);
    an_n = ~(DIGITS'(1) << idx);
  end
  // registered drive, dark during reset and the cycle after
  always_ff @(posedge clk)
    if (rst || !warm) begin
      seg_r <= SEG_BLANK;
      an_r <= '1;
    end else begin
      seg_r <= seg_n;
      an_r <= an_n;
    end
  assign bus.flags = flags_r;
  assign bus.busy = busy;
  assign bus.seg = seg_r;
  assign bus.an = an_r;
endmodule

// File: tb/tb_alu_seq_display.sv
// tb_alu_seq_display: directed checks of ALU flags, conversion timing and scanned display
module tb_alu_seq_display;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int tests = 0;
  int fails = 0;
  int bad = 0;
  int busy_cnt;
  logic mon = 1'b0;
  logic seen;
  logic [31:0] disp;
  logic [3:0] an_seq [4] = '{4'hE, 4'hD, 4'hB, 4'h7};
  alu_seq_display_if #(.WIDTH(8), .DIGITS(4)) bus ();
  alu_seq_display #(.WIDTH(8), .DIGITS(4), .DIVIDER(4)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  always @(negedge clk)
    if (mon && ((bus.an == 4'hE && bus.seg == 8'hF8) || (bus.an == 4'hD && bus.seg == 8'hB0))) bad++;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic apply(input logic [2:0] o, input logic sm, input logic [7:0] d, input logic la, input logic lb);
    bus.op = o;
    bus.signed_mode = sm;
    bus.din = d;
    bus.load_a = la;
    bus.load_b = lb;
    step(1);
    bus.load_a = 1'b0;
    bus.load_b = 1'b0;
  endtask
  task automatic read_disp(output logic [31:0] v);
    v = '0;
    repeat (16) begin
      step(1);
      for (int i = 0; i < 4; i++)
        if (bus.an == ~(4'b1 << i)) v[8*i+:8] = bus.seg;
    end
  endtask
  task automatic wait_busy(output logic s);
    s = 1'b0;
    for (int i = 0; i < 10 && !s; i++) begin
      step(1);
      s = bus.busy;
    end
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
  initial begin
    bus.din = '0;
    bus.load_a = 1'b0;
    bus.load_b = 1'b0;
    bus.op = 3'b000;
    bus.signed_mode = 1'b0;
    step(2);
    check("rst_an", bus.an, 4'hF);
    check("rst_seg", bus.seg, 8'hFF);
    check("rst_flags", bus.flags, 4'h0);
    check("rst_busy", bus.busy, 1'b0);
    rst = 1'b0;
    step(1);
    check("post_rst_an", bus.an, 4'hF);
    check("post_rst_seg", bus.seg, 8'hFF);
    for (int k = 0; k < 20; k++) begin
      step(1);
      check($sformatf("an_scan%0d", k), bus.an, an_seq[(k / 4) % 4]);
    end
    read_disp(disp);
    check("rst_disp", disp, 32'hFFFF_FFC0);
    apply(3'b000, 1'b0, 8'd200, 1'b1, 1'b0);
    apply(3'b000, 1'b0, 8'd100, 1'b0, 1'b1);
    step(24);
    check("add_flags", bus.flags, 4'b0010);
    read_disp(disp);
    check("add_disp", disp, 32'hFFFF_9999);
    apply(3'b010, 1'b1, 8'd5, 1'b1, 1'b0);
    apply(3'b010, 1'b1, 8'd10, 1'b0, 1'b1);
    step(24);
    check("sub_flags", bus.flags, 4'b1010);
    read_disp(disp);
    check("sub_signed_disp", disp, 32'hBFFF_FF92);
    apply(3'b010, 1'b0, 8'd0, 1'b0, 1'b0);
    step(24);
    read_disp(disp);
    check("sub_unsigned_disp", disp, 32'hFFA4_92F9);
    apply(3'b010, 1'b0, 8'd127, 1'b1, 1'b0);
    step(24);
    bus.op = 3'b001;
    busy_cnt = 0;
    repeat (30) begin
      step(1);
      busy_cnt += int'(bus.busy);
    end
    check("inc_busy_cycles", busy_cnt, 9);
    check("inc_flags", bus.flags, 4'b1001);
    read_disp(disp);
    check("inc_disp", disp, 32'hFFF9_A480);
    mon = 1'b1;
    bus.op = 3'b000;
    wait_busy(seen);
    check("abort_start", seen, 1'b1);
    step(2);
    apply(3'b000, 1'b0, 8'd23, 1'b0, 1'b1);
    step(40);
    mon = 1'b0;
    check("abort_no_intermediate", bad, 0);
    check("abort_flags", bus.flags, 4'b1001);
    read_disp(disp);
    check("abort_disp", disp, 32'hFFF9_92C0);
    apply(3'b011, 1'b0, 8'd127, 1'b0, 1'b1);
    step(24);
    check("xor_zero_flags", bus.flags, 4'b0100);
    read_disp(disp);
    check("xor_zero_disp", disp, 32'hFFFF_FFC0);
    apply(3'b111, 1'b0, 8'd0, 1'b0, 1'b0);
    step(24);
    check("shr_flags", bus.flags, 4'b0010);
    read_disp(disp);
    check("shr_disp", disp, 32'hFFFF_82B0);
    apply(3'b110, 1'b0, 8'd0, 1'b0, 1'b0);
    step(24);
    check("shl_flags", bus.flags, 4'b1000);
    read_disp(disp);
    check("shl_disp", disp, 32'hFFA4_9299);
    bus.op = 3'b001;
    wait_busy(seen);
    check("rst_mid_start", seen, 1'b1);
    rst = 1'b1;
    bus.op = 3'b000;
    step(1);
    check("rst_mid_busy", bus.busy, 1'b0);
    check("rst_mid_flags", bus.flags, 4'h0);
    check("rst_mid_an", bus.an, 4'hF);
    rst = 1'b0;
    step(1);
    check("rst_mid_post_an", bus.an, 4'hF);
    read_disp(disp);
    check("rst_mid_disp", disp, 32'hFFFF_FFC0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
